// File: rtl/window_motor_drv_if.sv
// Command/status bundle between the window controller and the stepper driver.
// The controller (master) issues one-cycle open_cw / close_ccw pulses and
// observes coil drive, motion and limit status; the driver is the slave.
interface window_motor_drv_if #(
  parameter int POS_W = 16
);
  logic             open_cw;
  logic             close_ccw;
  logic [3:0]       coil;
  logic             moving;
  logic             at_open;
  logic             at_closed;
  logic [POS_W-1:0] position;

  modport master (
    output open_cw, close_ccw,
    input  coil, moving, at_open, at_closed, position
  );

  modport slave (
    input  open_cw, close_ccw,
    output coil, moving, at_open, at_closed, position
  );
endinterface

// File: rtl/window_motor_drv.sv
// Window motor driver: turns open/close command pulses into a clock-divided
// 4-coil unipolar stepper sequence, tracks position in steps and stops at
// both travel limits.
// Optional build macro WINDOW_HALF_STEP_EN selects the 8-entry half-step
// sequence (3-bit phase index); without it the 4-entry full-step sequence
// (2-bit phase index) is used.
module window_motor_drv #(
  parameter int STEP_DIV     = 50000,
  parameter int TRAVEL_STEPS = 200,
  parameter int POS_W        = 16
) (
  input  logic             clk,
  input  logic             n_reset,
  window_motor_drv_if.slave bus
);

`ifdef WINDOW_HALF_STEP_EN
  localparam int PH_W = 3;
`else
  localparam int PH_W = 2;
`endif

  localparam int               DIV_W  = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_TC = DIV_W'(STEP_DIV - 1);
  localparam logic [POS_W-1:0] POS_MAX = POS_W'(TRAVEL_STEPS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OPENING = 2'd1,
    CLOSING = 2'd2
  } state_t;

  // Coil pattern for a phase index, bit3..bit0 = A,B,C,D.
  function automatic logic [3:0] f_pattern(input logic [PH_W-1:0] idx);
    logic [3:0] pat;
`ifdef WINDOW_HALF_STEP_EN
    case (idx)
      3'd0:    pat = 4'b1000;
      3'd1:    pat = 4'b1100;
      3'd2:    pat = 4'b0100;
      3'd3:    pat = 4'b0110;
      3'd4:    pat = 4'b0010;
      3'd5:    pat = 4'b0011;
      3'd6:    pat = 4'b0001;
      default: pat = 4'b1001;
    endcase
`else
    case (idx)
      2'd0:    pat = 4'b1100;
      2'd1:    pat = 4'b0110;
      2'd2:    pat = 4'b0011;
      default: pat = 4'b1001;
    endcase
`endif
    return pat;
  endfunction

  state_t            r_state;
  logic [DIV_W-1:0]  r_div;
  logic [PH_W-1:0]   r_phase;
  logic [POS_W-1:0]  r_pos;
  logic [3:0]        r_coil;
  logic              r_moving;
  logic              r_at_open;
  logic              r_at_closed;

  state_t            w_state_nxt;
  logic [DIV_W-1:0]  w_div_nxt;
  logic [PH_W-1:0]   w_phase_nxt;
  logic [POS_W-1:0]  w_pos_nxt;
  logic [3:0]        w_coil_nxt;
  logic              w_moving_nxt;
  logic              w_at_open_nxt;
  logic              w_at_closed_nxt;

  // Both commands high at once cancel each other out in every state.
  logic w_open_cmd;
  logic w_close_cmd;
  assign w_open_cmd  = bus.open_cw   & ~bus.close_ccw;
  assign w_close_cmd = bus.close_ccw & ~bus.open_cw;

  // State, counters, position and registered outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, regardless of statement order.
    if (!n_reset) begin
      r_state     <= IDLE;
      r_div       <= '0;
      r_phase     <= '0;
      r_pos       <= '0;
      r_coil      <= 4'b0000;
      r_moving    <= 1'b0;
      r_at_open   <= 1'b0;
      r_at_closed <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_div       <= w_div_nxt;
      r_phase     <= w_phase_nxt;
      r_pos       <= w_pos_nxt;
      r_coil      <= w_coil_nxt;
      r_moving    <= w_moving_nxt;
      r_at_open   <= w_at_open_nxt;
      r_at_closed <= w_at_closed_nxt;
    end
  end

  // Next state, step divider, phase index and position.
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    w_state_nxt = r_state;
    w_div_nxt   = r_div;
    w_phase_nxt = r_phase;
    w_pos_nxt   = r_pos;
    case (r_state)
      IDLE: begin
        w_div_nxt = '0;
        if (w_open_cmd && (r_pos != POS_MAX)) begin
          w_state_nxt = OPENING;
        end else if (w_close_cmd && (r_pos != '0)) begin
          w_state_nxt = CLOSING;
        end
      end
      OPENING: begin
        if (w_close_cmd) begin
          // Reversal wins over a coincident step: restart the step period.
          w_state_nxt = CLOSING;
          w_div_nxt   = '0;
        end else if (r_div == DIV_TC) begin
          w_div_nxt   = '0;
          w_phase_nxt = r_phase + PH_W'(1);
          w_pos_nxt   = r_pos + POS_W'(1);
          if (w_pos_nxt == POS_MAX) begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_div_nxt = r_div + DIV_W'(1);
        end
      end
      CLOSING: begin
        if (w_open_cmd) begin
          w_state_nxt = OPENING;
          w_div_nxt   = '0;
        end else if (r_div == DIV_TC) begin
          w_div_nxt   = '0;
          w_phase_nxt = r_phase - PH_W'(1);
          w_pos_nxt   = r_pos - POS_W'(1);
          if (w_pos_nxt == '0) begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_div_nxt = r_div + DIV_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_div_nxt   = '0;
      end
    endcase
  end

  // Output values for the next edge, derived from the next state and position
  // so that status and coil change on the same edge as the motion itself.
  always_comb begin
    w_moving_nxt    = (w_state_nxt != IDLE);
    w_at_open_nxt   = (w_pos_nxt == POS_MAX);
    w_at_closed_nxt = (w_pos_nxt == '0);
    w_coil_nxt      = 4'b0000;
    if (w_state_nxt != IDLE) begin
      w_coil_nxt = f_pattern(w_phase_nxt);
    end
  end

  assign bus.coil      = r_coil;
  assign bus.moving    = r_moving;
  assign bus.at_open   = r_at_open;
  assign bus.at_closed = r_at_closed;
  assign bus.position  = r_pos;

endmodule

// File: tb/tb_window_motor_drv.sv
// Directed bench for window_motor_drv with STEP_DIV=4, TRAVEL_STEPS=5.
// Coil sequences follow the WINDOW_HALF_STEP_EN setting of the build.
module tb_window_motor_drv;

  localparam int STEP_DIV = 4;
  localparam int TRAVEL   = 5;
  localparam int POS_W    = 16;

  logic clk;
  logic n_reset;
  int   total;
  int   bad;

  window_motor_drv_if #(.POS_W(POS_W)) bus ();

  window_motor_drv #(
    .STEP_DIV    (STEP_DIV),
    .TRAVEL_STEPS(TRAVEL),
    .POS_W       (POS_W)
  ) dut (
    .clk    (clk),
    .n_reset(n_reset),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef WINDOW_HALF_STEP_EN
  logic [3:0] exp_open  [5] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110, 4'b0010};
  logic [3:0] exp_close [5] = '{4'b0011, 4'b0010, 4'b0110, 4'b0100, 4'b1100};
`else
  logic [3:0] exp_open  [5] = '{4'b1100, 4'b0110, 4'b0011, 4'b1001, 4'b1100};
  logic [3:0] exp_close [5] = '{4'b0110, 4'b1100, 4'b1001, 4'b0011, 4'b0110};
`endif

  // Advance one clock and settle just past the edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input logic op, input logic cl);
    bus.open_cw   = op;
    bus.close_ccw = cl;
    tick();
    bus.open_cw   = 1'b0;
    bus.close_ccw = 1'b0;
  endtask

  task automatic test_reset;
    n_reset = 1'b0;
    tick(2);
    n_reset = 1'b1;
    tick();
    total++; if (bus.coil !== 4'b0000) begin bad++; $display("FAIL reset_coil: got %b want 0000", bus.coil); end
    total++; if (bus.position !== 16'd0) begin bad++; $display("FAIL reset_pos: got %0d want 0", bus.position); end
    total++; if (bus.at_closed !== 1'b1) begin bad++; $display("FAIL reset_at_closed: got %b want 1", bus.at_closed); end
    total++; if (bus.at_open !== 1'b0) begin bad++; $display("FAIL reset_at_open: got %b want 0", bus.at_open); end
    total++; if (bus.moving !== 1'b0) begin bad++; $display("FAIL reset_moving: got %b want 0", bus.moving); end
  endtask

  task automatic test_close_at_zero;
    pulse(1'b0, 1'b1);
    tick(2);
    total++; if (bus.moving !== 1'b0) begin bad++; $display("FAIL close_at_zero_moving: got %b want 0", bus.moving); end
    total++; if (bus.position !== 16'd0) begin bad++; $display("FAIL close_at_zero_pos: got %0d want 0", bus.position); end
  endtask

  task automatic test_open;
    pulse(1'b1, 1'b0);
    total++; if (bus.moving !== 1'b1) begin bad++; $display("FAIL open_moving: got %b want 1", bus.moving); end
    for (int k = 0; k < 5; k++) begin
      for (int c = 0; c < STEP_DIV; c++) begin
        total++; if (bus.coil !== exp_open[k]) begin bad++; $display("FAIL open_coil s%0d c%0d: got %b want %b", k, c, bus.coil, exp_open[k]); end
        total++; if (bus.position !== 16'(k)) begin bad++; $display("FAIL open_pos s%0d c%0d: got %0d want %0d", k, c, bus.position, k); end
        total++; if (bus.at_open !== 1'b0) begin bad++; $display("FAIL open_at_open_early s%0d: got %b want 0", k, bus.at_open); end
        tick();
      end
    end
    total++; if (bus.position !== 16'd5) begin bad++; $display("FAIL open_final_pos: got %0d want 5", bus.position); end
    total++; if (bus.at_open !== 1'b1) begin bad++; $display("FAIL open_at_open: got %b want 1", bus.at_open); end
    total++; if (bus.moving !== 1'b0) begin bad++; $display("FAIL open_stop_moving: got %b want 0", bus.moving); end
    total++; if (bus.coil !== 4'b0000) begin bad++; $display("FAIL open_stop_coil: got %b want 0000", bus.coil); end
    total++; if (bus.at_closed !== 1'b0) begin bad++; $display("FAIL open_at_closed: got %b want 0", bus.at_closed); end
  endtask

  task automatic test_open_at_limit;
    pulse(1'b1, 1'b0);
    tick(STEP_DIV);
    total++; if (bus.moving !== 1'b0) begin bad++; $display("FAIL limit_moving: got %b want 0", bus.moving); end
    total++; if (bus.position !== 16'd5) begin bad++; $display("FAIL limit_pos: got %0d want 5", bus.position); end
    total++; if (bus.coil !== 4'b0000) begin bad++; $display("FAIL limit_coil: got %b want 0000", bus.coil); end
  endtask

  task automatic test_close;
    pulse(1'b0, 1'b1);
    total++; if (bus.moving !== 1'b1) begin bad++; $display("FAIL close_moving: got %b want 1", bus.moving); end
    for (int k = 0; k < 5; k++) begin
      for (int c = 0; c < STEP_DIV; c++) begin
        total++; if (bus.coil !== exp_close[k]) begin bad++; $display("FAIL close_coil s%0d c%0d: got %b want %b", k, c, bus.coil, exp_close[k]); end
        total++; if (bus.position !== 16'(5 - k)) begin bad++; $display("FAIL close_pos s%0d c%0d: got %0d want %0d", k, c, bus.position, 5 - k); end
        tick();
      end
    end
    total++; if (bus.position !== 16'd0) begin bad++; $display("FAIL close_final_pos: got %0d want 0", bus.position); end
    total++; if (bus.at_closed !== 1'b1) begin bad++; $display("FAIL close_at_closed: got %b want 1", bus.at_closed); end
    total++; if (bus.moving !== 1'b0) begin bad++; $display("FAIL close_stop_moving: got %b want 0", bus.moving); end
    total++; if (bus.coil !== 4'b0000) begin bad++; $display("FAIL close_stop_coil: got %b want 0000", bus.coil); end
  endtask

  task automatic test_reversal;
    pulse(1'b1, 1'b0);
    tick(2 * STEP_DIV);
    total++; if (bus.position !== 16'd2) begin bad++; $display("FAIL rev_pos_before: got %0d want 2", bus.position); end
    pulse(1'b0, 1'b1);
    total++; if (bus.moving !== 1'b1) begin bad++; $display("FAIL rev_moving: got %b want 1", bus.moving); end
    tick(STEP_DIV - 1);
    total++; if (bus.position !== 16'd2) begin bad++; $display("FAIL rev_div_cleared: got %0d want 2", bus.position); end
    tick();
    total++; if (bus.position !== 16'd1) begin bad++; $display("FAIL rev_first_step: got %0d want 1", bus.position); end
    tick(STEP_DIV);
    total++; if (bus.position !== 16'd0) begin bad++; $display("FAIL rev_final_pos: got %0d want 0", bus.position); end
    total++; if (bus.at_closed !== 1'b1) begin bad++; $display("FAIL rev_at_closed: got %b want 1", bus.at_closed); end
    total++; if (bus.moving !== 1'b0) begin bad++; $display("FAIL rev_stop_moving: got %b want 0", bus.moving); end
  endtask

  task automatic test_simultaneous;
    pulse(1'b1, 1'b1);
    tick();
    total++; if (bus.moving !== 1'b0) begin bad++; $display("FAIL simul_idle_moving: got %b want 0", bus.moving); end
    total++; if (bus.position !== 16'd0) begin bad++; $display("FAIL simul_idle_pos: got %0d want 0", bus.position); end
    pulse(1'b1, 1'b0);
    tick();
    pulse(1'b1, 1'b1);
    total++; if (bus.moving !== 1'b1) begin bad++; $display("FAIL simul_open_moving: got %b want 1", bus.moving); end
    tick();
    total++; if (bus.position !== 16'd0) begin bad++; $display("FAIL simul_open_pos_early: got %0d want 0", bus.position); end
    tick();
    total++; if (bus.position !== 16'd1) begin bad++; $display("FAIL simul_open_step: got %0d want 1", bus.position); end
  endtask

  // Continues the move from test_simultaneous (position 1, just stepped).
  task automatic test_reset_mid_motion;
    tick(2 * STEP_DIV);
    total++; if (bus.position !== 16'd3) begin bad++; $display("FAIL midrst_pos_before: got %0d want 3", bus.position); end
    total++; if (bus.moving !== 1'b1) begin bad++; $display("FAIL midrst_moving_before: got %b want 1", bus.moving); end
    n_reset = 1'b0;
    tick();
    n_reset = 1'b1;
    total++; if (bus.position !== 16'd0) begin bad++; $display("FAIL midrst_pos: got %0d want 0", bus.position); end
    total++; if (bus.coil !== 4'b0000) begin bad++; $display("FAIL midrst_coil: got %b want 0000", bus.coil); end
    total++; if (bus.moving !== 1'b0) begin bad++; $display("FAIL midrst_moving: got %b want 0", bus.moving); end
    total++; if (bus.at_closed !== 1'b1) begin bad++; $display("FAIL midrst_at_closed: got %b want 1", bus.at_closed); end
    tick(2 * STEP_DIV);
    total++; if (bus.position !== 16'd0) begin bad++; $display("FAIL midrst_no_steps: got %0d want 0", bus.position); end
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    n_reset       = 1'b0;
    bus.open_cw   = 1'b0;
    bus.close_ccw = 1'b0;
    test_reset();
    test_close_at_zero();
    test_open();
    test_open_at_limit();
    test_close();
    test_reversal();
    test_simultaneous();
    test_reset_mid_motion();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/window_motor_drv.md
Name: window_motor_drv

Overview:
Actuator end of the window control path. Consumes the one-cycle open_cw / close_ccw command pulses from the window state machine and drives a 4-coil unipolar stepper through a clock-divided phase sequence. Tracks window position in steps, stops at both travel limits and reports motion and limit status back to the controller.

Parameters:
STEP_DIV, 50000, clk cycles per motor step (>= 2)
TRAVEL_STEPS, 200, steps from fully closed to fully open (1 .. 2^POS_W-1)
POS_W, 16, width of position counter

Ports:
clk  input  1  system clock
n_reset  input  1  reset, synchronous, active-low
open_cw  input  1  command: run clockwise toward open
close_ccw  input  1  command: run counter-clockwise toward closed
coil  output  4  stepper coil drive, bit3..bit0 = A,B,C,D
moving  output  1  high while in OPENING or CLOSING
at_open  output  1  position == TRAVEL_STEPS
at_closed  output  1  position == 0
position  output  POS_W  current position in steps

Behaviour:
- Reset is synchronous, active-low, on clk rising edge; the clock is clk.
- Reset values: state IDLE, position 0 (window defined closed), div counter 0, phase index 0, coil 4'b0000, moving 0, at_closed 1, at_open 0.
- Reset mid-motion: the next edge applies full reset; position forced to 0; no further steps.
- States: IDLE, OPENING, CLOSING. Commands are sampled every clk.
- open_cw and close_ccw both high in the same cycle: treated as no command in every state.
- IDLE + open_cw, position < TRAVEL_STEPS -> OPENING. At position == TRAVEL_STEPS the command is ignored.
- IDLE + close_ccw, position > 0 -> CLOSING. At position == 0 the command is ignored.
- OPENING + close_ccw -> CLOSING on the next edge; div counter cleared; position unchanged. OPENING + open_cw is ignored.
- CLOSING + open_cw -> OPENING, with the same rules. CLOSING + close_ccw is ignored.
- Div counter:
  - Runs only while moving, counting 0..STEP_DIV-1. It is held at 0 in IDLE.
  - At terminal count: counter wraps to 0; phase index advances (+1 OPENING, -1 CLOSING, modulo sequence length); position +1 or -1.
  - The first step occurs STEP_DIV cycles after entering OPENING/CLOSING.
- Limit: on the edge where the step makes position reach TRAVEL_STEPS (OPENING) or 0 (CLOSING), state -> IDLE on that same edge.
- A command arriving on the limit edge follows the IDLE rules on the following cycle.
- coil is registered:
  - IDLE drives 4'b0000 (de-energised).
  - OPENING/CLOSING drive the pattern for the current phase index.
- Phase index is retained through IDLE, so the next move continues the sequence without a jump.
- Full-step sequence, index 0..3: 1100, 0110, 0011, 1001.
- moving, at_open and at_closed are registered and update on the same edge as state/position.
- position never leaves 0..TRAVEL_STEPS; no wrap-around.

Optional Feature:
WINDOW_HALF_STEP_EN
- Defined: 8-entry half-step sequence, index 0..7: 1000, 1100, 0100, 0110, 0010, 0011, 0001, 1001.
  - Each half-step counts as one position unit; TRAVEL_STEPS is counted in half-steps.
  - The phase index is 3 bits, modulo 8.
- Undefined: 4-entry full-step sequence with a 2-bit phase index, modulo 4.
- All other behaviour is identical.

Test Plan:
(All scenarios: STEP_DIV=4, TRAVEL_STEPS=5, full-step unless noted.)
1. Hold n_reset=0 for 2 cycles, then release -> coil=0000, position=0, at_closed=1, at_open=0, moving=0.
2. Pulse open_cw for 1 cycle.
   - moving=1 from the next cycle.
   - coil=1100 for 4 cycles, then 0110, 0011, 1001, 1100.
   - position increments every 4 cycles and reaches 5 after 20 cycles; at that edge at_open=1, moving=0, coil=0000.
3. From position 5:
   - Pulse open_cw -> no change.
   - Pulse close_ccw -> phase sequence runs in reverse; position decrements every 4 cycles and reaches 0 after 20 cycles; at_closed=1.
4. Reversal: pulse open_cw; when position=2, pulse close_ccw -> CLOSING on the next edge, div counter cleared, position=1 exactly 4 cycles later, and 0 four cycles after that.
5. Simultaneous commands:
   - open_cw=close_ccw=1 in IDLE at position 0 -> no motion.
   - Same while OPENING -> OPENING continues, step timing unaffected.
6. Reset mid-motion and half-step mode:
   - n_reset=0 during OPENING at position 3 -> next edge position=0, coil=0000, moving=0.
   - With WINDOW_HALF_STEP_EN defined, open from 0 -> coil 1000, 1100, 0100, 0110, 0010; at_open=1 when position=5.
